hamming_secded_13_8_encoder: RTL and testbench
==============================================

Name: hamming_secded_13_8_encoder

Overview:
Streaming SECDED encoder. Takes 8-bit data words and emits 13-bit Hamming(12,8) codewords plus an overall parity bit. Feeds the team's 13/8 SECDED decoder, using the same bit positions and parity ordering. Includes a one-shot error-injection unit (single/double bit flips) and a word counter, so the encoder/decoder pair can be exercised end to end.

Parameters:
CNT_W, 16, width of the transmitted-word counter (wraps modulo 2^CNT_W).

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  upstream data valid
in_ready  output  1  encoder can accept (registered)
in_data  input  8  data word
out_valid  output  1  codeword valid
out_ready  input  1  downstream accepts codeword
out_codeword  output  13  codeword; bit i = Hamming position i, bit 0 = overall parity
out_data  output  8  data field of out_codeword, post-injection
out_parity  output  5  {p8,p4,p2,p1,P0}, post-injection
inj_arm  input  1  one-cycle pulse: arm injection for next accepted word
inj_mode  input  2  00 none, 01 single flip, 10 double flip, 11 none
inj_pos_a  input  4  first flip position 0..12
inj_pos_b  input  4  second flip position 0..12 (double mode)
inj_pending  output  1  injection armed, not yet applied
word_count  output  CNT_W  count of completed output handshakes

Behaviour:
- Reset (rst=1 at an edge): out_valid=0, in_ready=0, inj_pending=0, word_count=0, skid buffer empty, out_codeword/out_data/out_parity=0. in_ready rises the first cycle after rst deasserts. Reset mid-transfer drops any buffered or held word and any pending injection.
- Data placement: pos3=d0; pos5,6,7=d1,d2,d3; pos9,10,11,12=d4..d7. Parity at positions 1,2,4,8.
- Parity equations:
  - p1 = d0^d1^d3^d4^d6
  - p2 = d0^d2^d3^d5^d6
  - p4 = d1^d2^d3^d7
  - p8 = d4^d5^d6^d7
  - P0 = XOR of positions 1..12, so the full 13-bit word has even parity.
- Pipeline: input accepted when in_valid&&in_ready. Encode and inject are done combinationally into a registered output stage. Latency: accept at edge N gives out_valid=1 after edge N; full throughput is 1 word/cycle.
- Skid buffer: one-entry. Ordering is strictly FIFO.
  - in_ready = !skid_full, registered.
  - If the output register is occupied and not drained while a word is accepted, the word goes to the skid.
  - Skid moves to the output on the next out handshake.
- Output hold: while out_valid && !out_ready, out_codeword, out_data and out_parity are stable.
- Injection:
  - inj_arm latches mode and positions and sets inj_pending. inj_arm while pending overwrites.
  - Applied to the next word entering the encode stage (from input or skid), which clears inj_pending in that cycle.
  - Flip mask: mode 01 = onehot(a); mode 10 = onehot(a)|onehot(b), so a==b gives a single flip. Positions 13..15 contribute no flip.
  - Mode 00/11 with inj_arm: nothing is latched and inj_pending stays 0.
  - inj_arm in the same cycle as an accept: the new settings apply to the following word, not the current one.
- out_data and out_parity are extracted from the post-injection codeword, using the same field mapping.
- word_count increments on each out_valid&&out_ready and wraps from 2^CNT_W-1 to 0.
- State: output register valid, skid valid, inj pending. Transitions are fully defined by the handshake rules above. There are no illegal states.

Test Plan:
- Reset, then in_data=0x00 -> out_codeword=0x0000, out_parity=0x00 one cycle later; word_count=1 after handshake.
- in_data=0x01 -> out_codeword=0x000F, out_parity=0x07. in_data=0xFF -> out_codeword=0x1EEE, out_parity=0x06.
- Back-to-back 0x01,0xFF,0x00 with out_ready held 0 for 3 cycles -> in_ready drops after 2nd accept; outputs stable; released in order 0x000F,0x1EEE,0x0000 with no loss.
- inj_arm with mode=01, pos_a=5, then data 0x00 -> out_codeword=0x0020, out_data=0x02, inj_pending 1->0; next word is unmodified. Through the decoder: single flag set, data corrected to 0x00.
- inj_arm with mode=10, a=3, b=9, then data 0x00 -> out_codeword=0x0208, out_data=0x11. Decoder double flag set. Mode 10 with a=b=0 -> out_codeword=0x0001.
- Assert rst while out_valid=1 and skid full -> next cycle out_valid=0, word_count=0, inj_pending=0; in_ready=1 the cycle after rst falls.

Source files
------------

// File: rtl/hamming_secded_13_8_encoder_if.sv
// Stream + injection-control bundle for the 13/8 SECDED encoder.
// Latency: n/a (wires only); the encoder registers every output it drives here.
// Backpressure: valid/ready on both the data input and the codeword output.
interface hamming_secded_13_8_encoder_if #(
    parameter int CNT_W = 16
);
    // Upstream data stream
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;

    // Downstream codeword stream
    logic             out_valid;
    logic             out_ready;
    logic [12:0]      out_codeword;
    logic [7:0]       out_data;
    logic [4:0]       out_parity;

    // Error-injection control and status
    logic             inj_arm;
    logic [1:0]       inj_mode;
    logic [3:0]       inj_pos_a;
    logic [3:0]       inj_pos_b;
    logic             inj_pending;

    // Completed output handshakes
    logic [CNT_W-1:0] word_count;

    // Producer/consumer side that surrounds the encoder
    modport master (
        output in_valid, in_data, out_ready,
               inj_arm, inj_mode, inj_pos_a, inj_pos_b,
        input  in_ready, out_valid, out_codeword, out_data, out_parity,
               inj_pending, word_count
    );

    // Encoder side
    modport slave (
        input  in_valid, in_data, out_ready,
               inj_arm, inj_mode, inj_pos_a, inj_pos_b,
        output in_ready, out_valid, out_codeword, out_data, out_parity,
               inj_pending, word_count
    );
endinterface

// File: rtl/hamming_secded_13_8_encoder.sv
// Streaming Hamming(12,8)+overall-parity encoder with one-shot bit-flip injection and word counter.
// Latency: 1 cycle from input accept to out_valid; 1 word/cycle sustained.
// Backpressure: one-entry skid holds a word while the output is stalled; in_ready = !skid_full, registered.
module hamming_secded_13_8_encoder #(
    parameter int CNT_W = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    hamming_secded_13_8_encoder_if.slave  bus
);

    // ------------------------------------------------------------------
    // Code construction
    // Bit i of the codeword is Hamming position i; bit 0 is overall parity.
    // Data sits at the non-power-of-two positions 3,5,6,7,9,10,11,12.
    // ------------------------------------------------------------------
    function automatic logic [12:0] encode(input logic [7:0] d);
        logic        p1;
        logic        p2;
        logic        p4;
        logic        p8;
        logic [12:0] cw;
        p1 = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        p2 = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        p4 = d[1] ^ d[2] ^ d[3] ^ d[7];
        p8 = d[4] ^ d[5] ^ d[6] ^ d[7];
        cw = {d[7:4], p8, d[3:1], p4, d[0], p2, p1, 1'b0};
        // Overall parity makes the full 13-bit word even
        cw[0] = ^cw[12:1];
        return cw;
    endfunction

    // Single-bit flip mask; positions beyond the codeword flip nothing
    function automatic logic [12:0] onehot_pos(input logic [3:0] pos);
        logic [12:0] m;
        m = '0;
        if (pos <= 4'd12) begin
            m[pos] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [1:0] INJ_SINGLE = 2'b01;
    localparam logic [1:0] INJ_DOUBLE = 2'b10;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic             out_vld_q,  out_vld_d;
    logic [12:0]      out_cw_q,   out_cw_d;
    logic             skid_vld_q, skid_vld_d;
    logic [7:0]       skid_dat_q, skid_dat_d;
    logic             in_rdy_q,   in_rdy_d;
    logic             inj_pend_q, inj_pend_d;
    logic [12:0]      inj_mask_q, inj_mask_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;

    // ------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------
    logic        in_acc;
    logic        out_hs;
    logic        out_free;
    logic        load_en;
    logic [7:0]  load_dat;
    logic [12:0] load_cw;
    logic        arm_vld;
    logic [12:0] arm_mask;

    assign in_acc   = bus.in_valid && in_rdy_q;
    assign out_hs   = out_vld_q && bus.out_ready;
    // Output register can take a new word this cycle (empty or draining)
    assign out_free = !out_vld_q || bus.out_ready;

    // Route words: skid drains first to keep FIFO order, otherwise input goes straight to output
    always_comb begin
        out_vld_d  = out_vld_q;
        skid_vld_d = skid_vld_q;
        skid_dat_d = skid_dat_q;
        load_en    = 1'b0;
        load_dat   = bus.in_data;
        if (out_free) begin
            if (skid_vld_q) begin
                load_en    = 1'b1;
                load_dat   = skid_dat_q;
                skid_vld_d = in_acc;
                if (in_acc) begin
                    skid_dat_d = bus.in_data;
                end
            end else if (in_acc) begin
                load_en  = 1'b1;
                load_dat = bus.in_data;
            end
            out_vld_d = load_en;
        end else if (in_acc) begin
            // Output is stalled: park the accepted word
            skid_vld_d = 1'b1;
            skid_dat_d = bus.in_data;
        end
        in_rdy_d = !skid_vld_d;
    end

    // Encode the word entering the output stage and apply any pending flips
    always_comb begin
        load_cw  = encode(load_dat) ^ (inj_pend_q ? inj_mask_q : 13'd0);
        out_cw_d = load_en ? load_cw : out_cw_q;
    end

    // Injection arming: a new arm in the same cycle as a load targets the following word
    always_comb begin
        arm_vld    = bus.inj_arm && ((bus.inj_mode == INJ_SINGLE) || (bus.inj_mode == INJ_DOUBLE));
        arm_mask   = onehot_pos(bus.inj_pos_a);
        if (bus.inj_mode == INJ_DOUBLE) begin
            arm_mask = arm_mask | onehot_pos(bus.inj_pos_b);
        end
        inj_pend_d = inj_pend_q;
        inj_mask_d = inj_mask_q;
        if (load_en) begin
            inj_pend_d = 1'b0;
        end
        if (arm_vld) begin
            inj_pend_d = 1'b1;
            inj_mask_d = arm_mask;
        end
    end

    // Count completed output handshakes, wrapping naturally
    always_comb begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, out_hs};
    end

    // Pipeline and skid registers
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q  <= 1'b0;
            out_cw_q   <= '0;
            skid_vld_q <= 1'b0;
            skid_dat_q <= '0;
            in_rdy_q   <= 1'b0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_cw_q   <= out_cw_d;
            skid_vld_q <= skid_vld_d;
            skid_dat_q <= skid_dat_d;
            in_rdy_q   <= in_rdy_d;
        end
    end

    // Injection settings register
    always_ff @(posedge clk) begin
        if (rst) begin
            inj_pend_q <= 1'b0;
            inj_mask_q <= '0;
        end else begin
            inj_pend_q <= inj_pend_d;
            inj_mask_q <= inj_mask_d;
        end
    end

    // Word counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: data and parity fields are cut from the post-injection word
    // ------------------------------------------------------------------
    assign bus.in_ready     = in_rdy_q;
    assign bus.out_valid    = out_vld_q;
    assign bus.out_codeword = out_cw_q;
    assign bus.out_data     = {out_cw_q[12:9], out_cw_q[7:5], out_cw_q[3]};
    assign bus.out_parity   = {out_cw_q[8], out_cw_q[4], out_cw_q[2], out_cw_q[1], out_cw_q[0]};
    assign bus.inj_pending  = inj_pend_q;
    assign bus.word_count   = cnt_q;

endmodule

// File: tb/tb_hamming_secded_13_8_encoder.sv
// Bench for the 13/8 SECDED encoder: directed code points, backpressure, injection, reset, random stream.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: out_ready is driven directly and randomly toggled in the streaming phase.
module tb_hamming_secded_13_8_encoder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hamming_secded_13_8_encoder_if #(.CNT_W(16)) bus ();

    hamming_secded_13_8_encoder #(.CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_err    = 0;
    int          exp_cnt  = 0;
    logic [12:0] sb[$];

    // Reference encoder built from the Hamming definition: data fills the
    // non-power-of-two positions in order, each parity bit 2^b covers every
    // position whose index has bit b set, bit 0 evens out the whole word.
    function automatic logic [12:0] ref_encode(input logic [7:0] d);
        logic [12:0] cw;
        logic        par;
        int          k;
        cw = '0;
        k  = 0;
        for (int p = 1; p <= 12; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p] = d[k];
                k++;
            end
        end
        for (int b = 0; b < 4; b++) begin
            par = 1'b0;
            for (int p = 1; p <= 12; p++) begin
                if ((p & (1 << b)) != 0) par = par ^ cw[p];
            end
            cw[1 << b] = par;
        end
        cw[0] = ^cw[12:1];
        return cw;
    endfunction

    function automatic logic [7:0] field_data(input logic [12:0] cw);
        return {cw[12:9], cw[7:5], cw[3]};
    endfunction

    function automatic logic [4:0] field_par(input logic [12:0] cw);
        return {cw[8], cw[4], cw[2], cw[1], cw[0]};
    endfunction

    // Decoder view: XOR of indices of set bits among positions 1..12
    function automatic logic [3:0] syndrome(input logic [12:0] cw);
        logic [3:0] s;
        s = 4'd0;
        for (int p = 1; p <= 12; p++) begin
            if (cw[p]) s = s ^ 4'(p);
        end
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One word through an idle pipeline with out_ready high
    task automatic xfer(input string tag, input logic [7:0] d, input logic [12:0] exp_cw);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_cw"},  32'(bus.out_codeword), 32'(exp_cw));
        chk({tag, "_dat"}, 32'(bus.out_data), 32'(field_data(exp_cw)));
        chk({tag, "_par"}, 32'(bus.out_parity), 32'(field_par(exp_cw)));
        step();
        exp_cnt++;
        chk({tag, "_cnt"}, 32'(bus.word_count), 32'(exp_cnt & 16'hFFFF));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [12:0] cw;
        logic [12:0] held;

        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        bus.inj_arm   = 1'b0;
        bus.inj_mode  = 2'b00;
        bus.inj_pos_a = 4'd0;
        bus.inj_pos_b = 4'd0;

        // Reset state
        rst = 1'b1;
        step();
        step();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready), 32'd0);
        chk("rst_pending",   32'(bus.inj_pending), 32'd0);
        chk("rst_count",     32'(bus.word_count), 32'd0);
        chk("rst_cw",        32'(bus.out_codeword), 32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Directed code points
        xfer("d00", 8'h00, 13'h0000);
        xfer("d01", 8'h01, 13'h000F);
        chk("d01_par_const", 32'(field_par(13'h000F)), 32'(5'h07));
        xfer("dFF", 8'hFF, 13'h1EEE);
        chk("model_01", 32'(ref_encode(8'h01)), 32'h000F);
        chk("model_FF", 32'(ref_encode(8'hFF)), 32'h1EEE);

        // Back-to-back with output stalled for three edges
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h01;
        step();
        bus.in_data = 8'hFF;
        step();
        chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        held = bus.out_codeword;
        bus.in_data = 8'h00;
        step();
        chk("bp_hold_cw", 32'(bus.out_codeword), 32'h000F);
        chk("bp_hold_stable", 32'(bus.out_codeword), 32'(held));
        chk("bp_in_ready_still_low", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        step();
        exp_cnt++;
        chk("bp_second", 32'(bus.out_codeword), 32'h1EEE);
        chk("bp_in_ready_back", 32'(bus.in_ready), 32'd1);
        step();
        exp_cnt++;
        bus.in_valid = 1'b0;
        chk("bp_third", 32'(bus.out_codeword), 32'h0000);
        chk("bp_third_vld", 32'(bus.out_valid), 32'd1);
        step();
        exp_cnt++;
        chk("bp_drained", 32'(bus.out_valid), 32'd0);
        chk("bp_count", 32'(bus.word_count), 32'(exp_cnt));

        // Single flip at position 5
        bus.inj_arm   = 1'b1;
        bus.inj_mode  = 2'b01;
        bus.inj_pos_a = 4'd5;
        step();
        bus.inj_arm = 1'b0;
        chk("inj1_pending", 32'(bus.inj_pending), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h00;
        step();
        bus.in_valid = 1'b0;
        cw = bus.out_codeword;
        chk("inj1_cw", 32'(cw), 32'h0020);
        chk("inj1_dat", 32'(bus.out_data), 32'h02);
        chk("inj1_cleared", 32'(bus.inj_pending), 32'd0);
        chk("inj1_dec_single", 32'(^cw), 32'd1);
        chk("inj1_dec_syn", 32'(syndrome(cw)), 32'd5);
        chk("inj1_dec_fix", 32'(field_data(cw ^ (13'd1 << syndrome(cw)))), 32'h00);
        step();
        exp_cnt++;
        xfer("inj1_next", 8'h00, 13'h0000);

        // Double flip at positions 3 and 9
        bus.inj_arm   = 1'b1;
        bus.inj_mode  = 2'b10;
        bus.inj_pos_a = 4'd3;
        bus.inj_pos_b = 4'd9;
        step();
        bus.inj_arm = 1'b0;
        xfer("inj2", 8'h00, 13'h0208);
        cw = 13'h0208;
        chk("inj2_dat_const", 32'(field_data(cw)), 32'h11);
        chk("inj2_dec_double", 32'((^cw) == 1'b0 && syndrome(cw) != 4'd0), 32'd1);

        // Double mode with identical positions flips one bit
        bus.inj_arm   = 1'b1;
        bus.inj_mode  = 2'b10;
        bus.inj_pos_a = 4'd0;
        bus.inj_pos_b = 4'd0;
        step();
        bus.inj_arm = 1'b0;
        xfer("inj_same", 8'h00, 13'h0001);

        // Arm coincides with an accept: current word untouched, next flipped
        bus.inj_arm   = 1'b1;
        bus.inj_mode  = 2'b01;
        bus.inj_pos_a = 4'd0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h01;
        bus.out_ready = 1'b1;
        step();
        bus.inj_arm  = 1'b0;
        bus.in_valid = 1'b0;
        chk("arm_acc_cw", 32'(bus.out_codeword), 32'h000F);
        chk("arm_acc_pending", 32'(bus.inj_pending), 32'd1);
        step();
        exp_cnt++;
        xfer("arm_acc_next", 8'h01, 13'h000E);

        // Random stream with random backpressure, scored in order
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = 8'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("rnd_spurious", 32'(bus.out_valid), 32'd0);
                end else begin
                    chk("rnd_cw", 32'(bus.out_codeword), 32'(sb.pop_front()));
                end
                exp_cnt++;
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(ref_encode(bus.in_data));
            end
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    chk("drain_spurious", 32'(bus.out_valid), 32'd0);
                end else begin
                    chk("drain_cw", 32'(bus.out_codeword), 32'(sb.pop_front()));
                end
                exp_cnt++;
            end
            step();
        end
        chk("rnd_all_delivered", 32'(sb.size()), 32'd0);
        chk("rnd_count", 32'(bus.word_count), 32'(exp_cnt & 16'hFFFF));

        // Reset with output held, skid full and injection pending
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h55;
        step();
        bus.in_data = 8'hAA;
        step();
        bus.in_valid  = 1'b0;
        bus.inj_arm   = 1'b1;
        bus.inj_mode  = 2'b01;
        bus.inj_pos_a = 4'd1;
        step();
        bus.inj_arm = 1'b0;
        chk("mid_out_valid", 32'(bus.out_valid), 32'd1);
        chk("mid_skid_full", 32'(bus.in_ready), 32'd0);
        chk("mid_pending", 32'(bus.inj_pending), 32'd1);
        rst = 1'b1;
        step();
        chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_count", 32'(bus.word_count), 32'd0);
        chk("mrst_pending", 32'(bus.inj_pending), 32'd0);
        chk("mrst_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("mrst_in_ready_up", 32'(bus.in_ready), 32'd1);
        chk("mrst_no_stale", 32'(bus.out_valid), 32'd0);
        step();
        chk("mrst_skid_dropped", 32'(bus.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
